// File: rtl/fifo_pkg.sv
// Shared definitions for the threshold FIFO: almost-full select
// encodings and the level decode used by the top.
package fifo_pkg;

    localparam logic [1:0] THR_FULL = 2'b00;
    localparam logic [1:0] THR_M1   = 2'b01;
    localparam logic [1:0] THR_M2   = 2'b10;
    localparam logic [1:0] THR_HALF = 2'b11;

    function automatic int unsigned thr_level(
        input int unsigned depth,
        input logic [1:0]  sel
    );
        int unsigned lvl;
        lvl = depth;
        case (sel)
            THR_FULL: lvl = depth;
            THR_M1:   lvl = depth - 1;
            THR_M2:   lvl = depth - 2;
            THR_HALF: lvl = depth / 2;
            default:  lvl = depth;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_thresh_pipe.sv
// Synchronous FIFO with programmable almost-full level, registered
// read port, occupancy count and sticky overflow/underflow flags.
module fifo_thresh_pipe
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enqueue_w,
    input  logic [DATA_WIDTH-1:0] data_in_w,
    output logic                  fifo_full_w,
    input  logic                  dequeue_w,
    output logic                  data_valid_r,
    output logic [DATA_WIDTH-1:0] rdata_r,
    input  logic [1:0]            full_threshold,
    output logic [CW-1:0]         count_r,
    output logic                  empty_w,
    output logic                  overflow_r,
    output logic                  underflow_r,
    input  logic                  clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] head;
    logic [CW-1:0]         lvl;
    logic                  rd_ok;
    logic                  wr_ok;

    // A write at hard full is still taken when a read frees a slot.
    assign rd_ok = dequeue_w & (count_r != '0);
    assign wr_ok = enqueue_w & ((count_r != FULL_CNT) | rd_ok);

    assign lvl         = CW'(thr_level(DEPTH, full_threshold));
    assign fifo_full_w = (count_r >= lvl);
    assign empty_w     = (count_r == '0);

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_ok),
        .waddr(wr_ptr),
        .wdata(data_in_w),
        .raddr(rd_ptr),
        .rdata(head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_r <= count_r + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid_r <= 1'b0;
            rdata_r      <= '0;
        end else begin
            data_valid_r <= rd_ok;
            if (rd_ok) begin
                rdata_r <= head;
            end
        end
    end

    // Setting a flag takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (enqueue_w & ~wr_ok) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (dequeue_w & (count_r == '0)) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

endmodule
